// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // cs_sel width: one bit minimum, even for a single slave.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: tick strobe, leading/trailing edge flags and edge count.
module spi_clkgen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic                               run,
    output logic                               tick,
    output logic                               lead_edge,
    output logic                               trail_edge,
    output logic [$clog2(2*DATA_W+1)-1:0]      edge_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EC_W  = $clog2(2*DATA_W+1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [EC_W-1:0]  EC_LAST  = EC_W'(2*DATA_W);

    logic [DIV_W-1:0] div_cnt;

    assign tick       = run && (div_cnt == '0);
    // Once all 2*DATA_W toggles are done, ticks only time the trailing gap.
    assign lead_edge  = tick && (edge_cnt != EC_LAST) && !edge_cnt[0];
    assign trail_edge = tick && edge_cnt[0];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            div_cnt  <= DIV_LOAD;
            edge_cnt <= '0;
        end else if (run) begin
            if (div_cnt == '0) begin
                div_cnt <= DIV_LOAD;
                if (edge_cnt != EC_LAST) begin
                    edge_cnt <= edge_cnt + EC_W'(1);
                end
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: per-transfer CPOL/CPHA, programmable divider,
// selectable bit order and one-hot active-low chip selects.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CS    = 1,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_send_enable,
    input  logic [DATA_W-1:0]             data_send_master,
    input  logic [cs_width(NUM_CS)-1:0]   cs_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          miso,
    output logic                          busy,
    output logic [DATA_W-1:0]             data_receive_master,
    output logic                          data_receive_master_enable,
    output logic [NUM_CS-1:0]             cs_n,
    output logic                          sclk,
    output logic                          mosi
);

    localparam int EC_W = $clog2(2*DATA_W+1);

    spi_state_t        state;
    spi_mode_t         mode;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_next;
    logic [NUM_CS-1:0] cs_dec;
    logic              start_ok;
    logic              tick;
    logic              lead_edge;
    logic              trail_edge;
    logic              last_edge;
    logic [EC_W-1:0]   edge_cnt;

    function automatic logic head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r, input logic b);
        return (MSB_FIRST != 0) ? {r[DATA_W-2:0], b} : {b, r[DATA_W-1:1]};
    endfunction

    assign tx_next   = (MSB_FIRST != 0) ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    assign start_ok  = data_send_enable && (32'(cs_sel) < NUM_CS);
    assign last_edge = trail_edge && (edge_cnt == EC_W'(2*DATA_W - 1));

    always_comb begin
        cs_dec = '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (32'(cs_sel) == i);
        end
    end

    spi_clkgen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .load       ((state == IDLE) && start_ok),
        .run        (state != IDLE),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .edge_cnt   (edge_cnt)
    );

    always_ff @(posedge clk) begin
        data_receive_master_enable <= 1'b0;
        if (rst) begin
            state               <= IDLE;
            mode                <= '0;
            busy                <= 1'b0;
            cs_n                <= '1;
            sclk                <= 1'b0;
            mosi                <= 1'b0;
            tx_sr               <= '0;
            rx_sr               <= '0;
            data_receive_master <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    sclk <= mode.cpol;
                    if (start_ok) begin
                        mode  <= {cpol, cpha};
                        sclk  <= cpol;
                        cs_n  <= ~cs_dec;
                        busy  <= 1'b1;
                        tx_sr <= data_send_master;
                        rx_sr <= '0;
                        if (!cpha) begin
                            mosi <= head(data_send_master);
                        end
                        state <= LEAD;
                    end
                end
                // The tick closing LEAD is itself sclk toggle 1, so the edge
                // count runs continuously from LEAD through SHIFT.
                LEAD, SHIFT: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (lead_edge) begin
                            if (mode.cpha) begin
                                mosi  <= head(tx_sr);
                                tx_sr <= tx_next;
                            end else begin
                                rx_sr <= shift_in(rx_sr, miso);
                            end
                        end else if (trail_edge) begin
                            if (mode.cpha) begin
                                rx_sr <= shift_in(rx_sr, miso);
                            end else if (!last_edge) begin
                                mosi  <= head(tx_next);
                                tx_sr <= tx_next;
                            end
                        end
                        state <= last_edge ? TRAIL : SHIFT;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs_n                       <= '1;
                        busy                       <= 1'b0;
                        data_receive_master        <= rx_sr;
                        data_receive_master_enable <= 1'b1;
                        state                      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three configurations, slave model and
// loopback, expected received words held in per-instance scoreboard queues.
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8-bit, MSB first, one slave, divider 2, driven by a slave model
    logic       en_a, cpol_a, cpha_a, busy_a, rxv_a, sclk_a, mosi_a;
    logic       miso_a = 1'b0;
    logic [0:0] sel_a, csn_a;
    logic [7:0] tx_a, rx_a;

    spi_master_param #(.DATA_W(8), .NUM_CS(1), .CLK_DIV(2), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .data_send_enable(en_a), .data_send_master(tx_a),
        .cs_sel(sel_a), .cpol(cpol_a), .cpha(cpha_a), .miso(miso_a), .busy(busy_a),
        .data_receive_master(rx_a), .data_receive_master_enable(rxv_a),
        .cs_n(csn_a), .sclk(sclk_a), .mosi(mosi_a));

    // Instance B: 8-bit, LSB first, loopback
    logic       en_b, cpol_b, cpha_b, busy_b, rxv_b, sclk_b, mosi_b;
    logic [0:0] sel_b, csn_b;
    logic [7:0] tx_b, rx_b;

    spi_master_param #(.DATA_W(8), .NUM_CS(1), .CLK_DIV(2), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .data_send_enable(en_b), .data_send_master(tx_b),
        .cs_sel(sel_b), .cpol(cpol_b), .cpha(cpha_b), .miso(mosi_b), .busy(busy_b),
        .data_receive_master(rx_b), .data_receive_master_enable(rxv_b),
        .cs_n(csn_b), .sclk(sclk_b), .mosi(mosi_b));

    // Instance C: 16-bit, loopback; five selects so cs_sel=5 is representable yet out of range
    logic        en_c, cpol_c, cpha_c, busy_c, rxv_c, sclk_c, mosi_c;
    logic [2:0]  sel_c;
    logic [4:0]  csn_c;
    logic [15:0] tx_c, rx_c;

    spi_master_param #(.DATA_W(16), .NUM_CS(5), .CLK_DIV(3), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .data_send_enable(en_c), .data_send_master(tx_c),
        .cs_sel(sel_c), .cpol(cpol_c), .cpha(cpha_c), .miso(mosi_c), .busy(busy_c),
        .data_receive_master(rx_c), .data_receive_master_enable(rxv_c),
        .cs_n(csn_c), .sclk(sclk_c), .mosi(mosi_c));

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] exp_q_c[$];
    int c0_a, c0_b, c0_c;

    // Slave model for A: shifts s_word out MSB first, captures mosi on its sample edges
    logic [7:0] s_word, cap_a;
    int         bidx;
    bit         armed_a = 1'b0;
    bit         was_a   = 1'b0;
    always @(sclk_a or armed_a) begin
        if (armed_a && !was_a) begin
            bidx  = 0;
            cap_a = '0;
            if (!cpha_a) miso_a = s_word[7];
        end else if (armed_a) begin
            if (sclk_a != cpol_a) begin
                if (cpha_a) begin
                    if (bidx < 8) miso_a = s_word[7-bidx];
                end else begin
                    cap_a = {cap_a[6:0], mosi_a};
                end
            end else begin
                if (cpha_a) begin
                    cap_a = {cap_a[6:0], mosi_a};
                    bidx++;
                end else begin
                    bidx++;
                    if (bidx < 8) miso_a = s_word[7-bidx];
                end
            end
        end
        was_a = armed_a;
    end

    // Mode-1 mosi capture for B, on falling (trailing) sclk edges, in transmit order
    logic [7:0] cap_b;
    bit         armed_b = 1'b0;
    bit         was_b   = 1'b0;
    always @(sclk_b or armed_b) begin
        if (armed_b && !was_b) cap_b = '0;
        else if (armed_b && sclk_b == 1'b0) cap_b = {cap_b[6:0], mosi_b};
        was_b = armed_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic start_a(input logic p, input logic h, input logic [7:0] tx,
                           input logic [7:0] sw, input bit push);
        cpol_a = p; cpha_a = h; tx_a = tx; s_word = sw; sel_a = '0; en_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_a    = 1'b0;
        c0_a    = cyc - 1;
        armed_a = 1'b1;
        if (push) exp_q_a.push_back(32'(sw));
        check("A cs_n low at cycle 1", 32'(csn_a), 0);
        check("A busy at cycle 1", 32'(busy_a), 1);
        check("A sclk idle level", 32'(sclk_a), 32'(p));
    endtask

    // Returns at the negedge of the done cycle.
    task automatic finish_a(input string tag, input logic [7:0] tx);
        logic [31:0] exp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxv_a) break;
        end
        armed_a = 1'b0;
        exp = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 32'hDEAD_BEEF;
        check({tag, " done pulse"}, 32'(rxv_a), 1);
        check({tag, " done cycle"}, 32'(cyc - c0_a), 35);
        check({tag, " rx word"}, 32'(rx_a), exp);
        check({tag, " mosi bits"}, 32'(cap_a), 32'(tx));
        check({tag, " cs_n released"}, 32'(csn_a), 1);
        check({tag, " busy released"}, 32'(busy_a), 0);
        check({tag, " sclk idle"}, 32'(sclk_a), 32'(cpol_a));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [31:0] exp;
        rst = 1'b1;
        en_a = 0; cpol_a = 0; cpha_a = 0; sel_a = '0; tx_a = '0;
        en_b = 0; cpol_b = 0; cpha_b = 0; sel_b = '0; tx_b = '0;
        en_c = 0; cpol_c = 0; cpha_c = 0; sel_c = '0; tx_c = '0;
        s_word = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset busy", 32'(busy_a), 0);
        check("reset cs_n", 32'(csn_a), 1);
        check("reset sclk", 32'(sclk_a), 0);
        check("reset mosi", 32'(mosi_a), 0);
        check("reset rx word", 32'(rx_a), 0);
        check("reset rx valid", 32'(rxv_a), 0);
        check("reset cs_n C", 32'(csn_c), 32'h1F);

        // Mode 0: send 0xD3, slave answers 0xC2
        start_a(1'b0, 1'b0, 8'hD3, 8'hC2, 1'b1);
        finish_a("mode0", 8'hD3);
        @(negedge clk);
        check("mode0 pulse one cycle", 32'(rxv_a), 0);
        check("mode0 rx word held", 32'(rx_a), 32'hC2);

        // Mode 3: send 0xA9, slave answers 0x35
        start_a(1'b1, 1'b1, 8'hA9, 8'h35, 1'b1);
        finish_a("mode3", 8'hA9);
        @(negedge clk);

        // Reset sampled at cycle 10 of a mode-3 transfer
        start_a(1'b1, 1'b1, 8'h5A, 8'hFF, 1'b0);
        for (int i = 0; i < 50 && (cyc - c0_a) < 10; i++) @(negedge clk);
        armed_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort cs_n", 32'(csn_a), 1);
        check("abort sclk", 32'(sclk_a), 0);
        check("abort busy", 32'(busy_a), 0);
        check("abort rx word", 32'(rx_a), 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rxv_a) pulses++;
        end
        check("abort no done pulse", 32'(pulses), 0);

        // Fresh transfer, then a back-to-back start in its done cycle
        start_a(1'b0, 1'b0, 8'h3C, 8'h96, 1'b1);
        finish_a("fresh", 8'h3C);
        start_a(1'b1, 1'b0, 8'h7E, 8'h81, 1'b1);
        finish_a("b2b", 8'h7E);
        @(negedge clk);

        // B: LSB first, mode 1, loopback of 0x01
        cpol_b = 1'b0; cpha_b = 1'b1; tx_b = 8'h01; sel_b = '0; en_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_b = 1'b0; c0_b = cyc - 1; armed_b = 1'b1;
        exp_q_b.push_back(32'h01);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxv_b) break;
        end
        armed_b = 1'b0;
        exp = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 32'hDEAD_BEEF;
        check("lsb done cycle", 32'(cyc - c0_b), 35);
        check("lsb loopback word", 32'(rx_b), exp);
        check("lsb mosi first bit only", 32'(cap_b), 32'h80);
        @(negedge clk);

        // C: 16-bit, select 2, loopback 0xBEEF, starts during busy ignored
        cpol_c = 1'b0; cpha_c = 1'b0; tx_c = 16'hBEEF; sel_c = 3'd2; en_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_c = 1'b0; c0_c = cyc - 1;
        exp_q_c.push_back(32'hBEEF);
        check("wide cs_n only [2] low", 32'(csn_c), 32'h1B);
        check("wide busy", 32'(busy_c), 1);
        sel_c = 3'd0; tx_c = 16'h1234; en_c = 1'b1;
        repeat (5) @(negedge clk);
        en_c = 1'b0;
        check("wide cs_n unchanged by busy start", 32'(csn_c), 32'h1B);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rxv_c) break;
        end
        exp = (exp_q_c.size() > 0) ? exp_q_c.pop_front() : 32'hDEAD_BEEF;
        check("wide done cycle", 32'(cyc - c0_c), 100);
        check("wide loopback word", 32'(rx_c), exp);
        @(negedge clk);
        check("wide no restart", 32'(busy_c), 0);

        // Out-of-range select is dropped
        sel_c = 3'd5; tx_c = 16'h5555; en_c = 1'b1;
        @(negedge clk);
        en_c = 1'b0;
        check("drop busy", 32'(busy_c), 0);
        check("drop cs_n", 32'(csn_c), 32'h1F);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rxv_c || busy_c) pulses++;
        end
        check("drop no activity", 32'(pulses), 0);
        check("drop rx word kept", 32'(rx_c), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
